// File: rtl/comp_seq_pkg.sv
// Shared types and helpers for the sequential slice-by-slice magnitude comparator.
package comp_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_res_t;

    function automatic int nslices(input int width, input int digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/comp_slice.sv
// Combinational DIGIT-bit unsigned magnitude compare, MSB-first priority chain.
module comp_slice
    import comp_seq_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output cmp_res_t         res
);

    logic decided;

    // The highest differing bit decides; lower bits are ignored once decided.
    always_comb begin
        res     = '{gt: 1'b0, eq: 1'b1, lt: 1'b0};
        decided = 1'b0;
        for (int i = DIGIT - 1; i >= 0; i--) begin
            if (!decided && (a[i] != b[i])) begin
                decided = 1'b1;
                res.gt  = a[i];
                res.lt  = b[i];
                res.eq  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/comp_seq_mag.sv
// Multi-cycle WIDTH-bit magnitude comparator: scans DIGIT-bit slices MSB-first,
// stops at the first differing slice, valid/ready on both sides.
module comp_seq_mag
    import comp_seq_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DIGIT = 4,
    localparam int NDIG  = nslices(WIDTH, DIGIT),
    localparam int CNT_W = $clog2(NDIG + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_gt,
    output logic             out_eq,
    output logic             out_lt,
    output logic [CNT_W-1:0] out_ndig
);

    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               sgn_q;
    logic [DIGIT-1:0]   sa;
    logic [DIGIT-1:0]   sb;
    cmp_res_t           res;

    assign in_ready = (state == IDLE) && !rst;

    // Operand capture: data only, loaded on accept, no reset needed.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            a_q   <= in_a;
            b_q   <= in_b;
            sgn_q <= in_signed;
        end
    end

    // Slice select; flipping the sign bit of the top slice turns a signed
    // compare into an unsigned one.
    always_comb begin
        sa = '0;
        sb = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx == IDX_W'(i)) begin
                sa = a_q[i*DIGIT +: DIGIT];
                sb = b_q[i*DIGIT +: DIGIT];
            end
        end
        if (sgn_q && (idx == IDX_W'(NDIG - 1))) begin
            sa[DIGIT-1] = ~sa[DIGIT-1];
            sb[DIGIT-1] = ~sb[DIGIT-1];
        end
    end

    comp_slice #(.DIGIT(DIGIT)) u_slice (
        .a   (sa),
        .b   (sb),
        .res (res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            out_valid <= 1'b0;
            out_gt    <= 1'b0;
            out_eq    <= 1'b0;
            out_lt    <= 1'b0;
            out_ndig  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        idx      <= IDX_W'(NDIG - 1);
                        out_ndig <= '0;
                        out_gt   <= 1'b0;
                        out_eq   <= 1'b0;
                        out_lt   <= 1'b0;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    out_ndig <= out_ndig + CNT_W'(1);
                    if (!res.eq) begin
                        out_gt    <= res.gt;
                        out_lt    <= res.lt;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (idx == '0) begin
                        out_eq    <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx - IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_comp_seq_mag.sv
// Self-checking bench for comp_seq_mag (WIDTH=32, DIGIT=4): directed table,
// handshake/reset corner sequences and a randomized back-to-back run.
module tb_comp_seq_mag;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic        out_gt;
    logic        out_eq;
    logic        out_lt;
    logic [3:0]  out_ndig;

    int vectors = 0;
    int miscompares = 0;

    comp_seq_mag #(.WIDTH(32), .DIGIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_gt    (out_gt),
        .out_eq    (out_eq),
        .out_lt    (out_lt),
        .out_ndig  (out_ndig)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic        gt;
        logic        eq;
        logic        lt;
        int          k;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: relation from plain signed/unsigned arithmetic, k from the
    // first nonzero nibble of a^b (sign-bit inversion does not change a^b).
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic gt, output logic eq, output logic lt, output int k);
        logic [31:0] x;
        if (s) begin
            gt = $signed(a) > $signed(b);
            lt = $signed(a) < $signed(b);
        end else begin
            gt = a > b;
            lt = a < b;
        end
        eq = (a == b);
        x  = a ^ b;
        k  = 8;
        for (int d = 1; d <= 8; d++) begin
            if (k == 8 && x[31 - 4*(d-1) -: 4] != 4'h0) k = d;
        end
        if (x == 32'h0) k = 8;
    endtask

    // Present operands, wait for accept, then count edges until out_valid.
    task automatic do_cmp(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output int lat);
        int n;
        in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("accept_timeout", {31'b0, in_ready}, 32'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = $urandom; in_b = $urandom; in_signed = ~s;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk("result_timeout", {31'b0, out_valid}, 32'h1);
    endtask

    initial begin
        vec_t tbl[10];
        int lat;
        logic eg, ee, el;
        int ek;

        tbl[0] = '{32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        tbl[1] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1};
        tbl[2] = '{32'h12345678, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b0, 8};
        tbl[3] = '{32'h12345678, 32'h12345678, 1'b1, 1'b0, 1'b1, 1'b0, 8};
        tbl[4] = '{32'h12345679, 32'h12345678, 1'b0, 1'b1, 1'b0, 1'b0, 8};
        tbl[5] = '{32'h12305678, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b1, 4};
        tbl[6] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1, 1};
        tbl[7] = '{32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        tbl[8] = '{32'h00000005, 32'h00000009, 1'b0, 1'b0, 1'b0, 1'b1, 8};
        tbl[9] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b1, 1'b0, 1'b0, 1};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; out_ready = 1'b1;
        #3;
        chk("rst_in_ready", {31'b0, in_ready}, 32'h0);
        chk("rst_outs", {27'b0, out_valid, out_gt, out_eq, out_lt, 1'b0}, 32'h0);
        chk("rst_ndig", {28'b0, out_ndig}, 32'h0);
        #19 rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'h1);

        for (int i = 0; i < 10; i++) begin
            do_cmp(tbl[i].a, tbl[i].b, tbl[i].s, lat);
            chk($sformatf("tbl%0d_flags", i), {29'b0, out_gt, out_eq, out_lt},
                {29'b0, tbl[i].gt, tbl[i].eq, tbl[i].lt});
            chk($sformatf("tbl%0d_ndig", i), {28'b0, out_ndig}, 32'(tbl[i].k));
            chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].k));
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_release", i), {30'b0, out_valid, in_ready}, 32'h1);
        end

        // Backpressure: result must hold for 5 cycles with out_ready low.
        out_ready = 1'b0;
        do_cmp(32'h5, 32'h9, 1'b0, lat);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp_hold", {26'b0, out_valid, in_ready, out_gt, out_eq, out_lt, 1'b0}, 32'b100010);
            chk("bp_ndig", {28'b0, out_ndig}, 32'h8);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", {30'b0, out_valid, in_ready}, 32'h1);

        // Async reset mid-scan.
        in_a = 32'h12345678; in_b = 32'h12345678; in_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_scan", {27'b0, out_valid, out_gt, out_eq, out_lt, in_ready}, 32'h0);
        @(posedge clk); #3 rst = 1'b0;
        #1;
        chk("arst_scan_ready", {31'b0, in_ready}, 32'h1);
        do_cmp(32'hFFFFFFFF, 32'h0, 1'b1, lat);
        chk("arst_fresh", {29'b0, out_gt, out_eq, out_lt}, 32'b001);
        @(posedge clk); #1;

        // Async reset while a result is held in DONE.
        out_ready = 1'b0;
        do_cmp(32'h1, 32'h2, 1'b0, lat);
        #3 rst = 1'b1;
        #1;
        chk("arst_done", {27'b0, out_valid, out_gt, out_eq, out_lt, in_ready}, 32'h0);
        @(posedge clk); #3 rst = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;

        // Back-to-back with in_valid held high and operands changing mid-scan.
        begin
            logic [31:0] a, b, ca, cb;
            logic s, cs;
            int n;
            a = $urandom; b = $urandom; s = 1'b0;
            in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
            for (int t = 0; t < 1000; t++) begin
                n = 0;
                while (!in_ready && n < 50) begin
                    @(posedge clk); #1; n++;
                end
                if (!in_ready) begin
                    chk("b2b_accept_timeout", {31'b0, in_ready}, 32'h1);
                    break;
                end
                ca = a; cb = b; cs = s;
                @(posedge clk); #1;
                chk("b2b_single_accept", {31'b0, in_ready}, 32'h0);
                case ($urandom % 4)
                    0: begin a = $urandom; b = a; end
                    1: begin a = $urandom; b = a ^ 32'h1; end
                    2: begin a = $urandom; b = a ^ (32'h1 << ($urandom % 32)); end
                    default: begin a = $urandom; b = $urandom; end
                endcase
                s = 1'($urandom % 2);
                in_a = a; in_b = b; in_signed = s;
                lat = 0;
                while (!out_valid && lat < 40) begin
                    @(posedge clk); #1; lat++;
                end
                model(ca, cb, cs, eg, ee, el, ek);
                chk("b2b_flags", {29'b0, out_gt, out_eq, out_lt}, {29'b0, eg, ee, el});
                chk("b2b_ndig", {28'b0, out_ndig}, 32'(ek));
                chk("b2b_lat", 32'(lat), 32'(ek));
                @(posedge clk); #1;
                chk("b2b_release", {30'b0, out_valid, in_ready}, 32'h1);
            end
            in_valid = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
